// File: rtl/sr_drive_pkg.sv
// Shared types, default timing constants and counter-width helper for the
// sr_latch drive controller.
package sr_drive_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET_P = 2'd1,
        ST_RST_P = 2'd2,
        ST_GAP   = 2'd3
    } drv_state_e;

    localparam int DEF_DEB_CYCLES   = 4;
    localparam int DEF_PULSE_CYCLES = 3;
    localparam int DEF_GAP_CYCLES   = 2;

    // Bits needed to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sr_drive_ctrl_debounce.sv
// One request channel: 2-FF synchroniser, stability debounce and rising-edge
// detect on the filtered level.
module sr_debounce
    import sr_drive_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    output logic o_filt,
    output logic o_evt
);

    localparam int              CW   = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          filt_q;
    logic          filt_dly_q;
    logic [CW-1:0] cnt_q;

    // Synchronise, then only accept a new level after it has differed from
    // the filtered level for DEB_CYCLES consecutive cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= i_req;
            s2_q       <= s1_q;
            filt_dly_q <= filt_q;
            if (s2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q >= TERM) begin
                filt_q <= s2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign o_filt = filt_q;
    assign o_evt  = filt_q & ~filt_dly_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drive controller for sr_latch: debounced set/reset requests become mutually
// exclusive fixed-width pulses separated by a guard gap.
module sr_drive_ctrl
    import sr_drive_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set_req,
    input  logic i_rst_req,
    output logic o_s,
    output logic o_r,
    output logic o_busy,
    output logic o_state_q,
    output logic o_conflict
);

    localparam int            MAXC   = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int            CW     = cnt_width(MAXC);
    localparam logic [CW-1:0] P_TERM = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] G_TERM = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    logic [1:0]    unused_filt_s;
    logic          evt_set_s;
    logic          evt_rst_s;
    logic          req_set_s;
    logic          req_rst_s;

    drv_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          pend_set_q;
    logic          pend_rst_q;
    logic          s_q;
    logic          r_q;
    logic          busy_q;
    logic          latch_q;
    logic          conflict_q;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req  (i_set_req),
        .o_filt (unused_filt_s[0]),
        .o_evt  (evt_set_s)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_req  (i_rst_req),
        .o_filt (unused_filt_s[1]),
        .o_evt  (evt_rst_s)
    );

    assign req_set_s = evt_set_s | pend_set_q;
    assign req_rst_s = evt_rst_s | pend_rst_q;

    // Pulse sequencer; every output is assigned alongside the state it belongs to.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_set_q <= 1'b0;
            pend_rst_q <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            latch_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (req_set_s && req_rst_s) begin
                        conflict_q <= 1'b1;
                        pend_set_q <= 1'b0;
                        pend_rst_q <= 1'b0;
                    end else if (req_set_s) begin
                        state_q    <= ST_SET_P;
                        pend_set_q <= 1'b0;
                        s_q        <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (req_rst_s) begin
                        state_q    <= ST_RST_P;
                        pend_rst_q <= 1'b0;
                        r_q        <= 1'b1;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SET_P, ST_RST_P: begin
                    pend_set_q <= pend_set_q | evt_set_s;
                    pend_rst_q <= pend_rst_q | evt_rst_s;
                    if (cnt_q >= P_TERM) begin
                        latch_q <= (state_q == ST_SET_P);
                        s_q     <= 1'b0;
                        r_q     <= 1'b0;
                        cnt_q   <= '0;
                        // A zero-length gap returns straight to IDLE.
                        if (GAP_CYCLES == 0) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_GAP: begin
                    pend_set_q <= pend_set_q | evt_set_s;
                    pend_rst_q <= pend_rst_q | evt_rst_s;
                    if (cnt_q >= G_TERM) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_s        = s_q;
    assign o_r        = r_q;
    assign o_busy     = busy_q;
    assign o_state_q  = latch_q;
    assign o_conflict = conflict_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Scoreboard bench for sr_drive_ctrl: a timestamp-based reference model
// predicts each pulse (kind, start edge, width); a monitor checks DUT pulses.
module tb_sr_drive_ctrl;

    localparam int DEB = 4;
    localparam int PUL = 3;
    localparam int GAP = 2;
    localparam int K_SET  = 0;
    localparam int K_RST  = 1;
    localparam int K_CONF = 2;

    logic i_clk = 1'b0;
    logic i_rst;
    logic i_set_req;
    logic i_rst_req;
    logic o_s, o_r, o_busy, o_state_q, o_conflict;

    always #5 i_clk = ~i_clk;

    sr_drive_ctrl #(.DEB_CYCLES(DEB), .PULSE_CYCLES(PUL), .GAP_CYCLES(GAP)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_set_req  (i_set_req),
        .i_rst_req  (i_rst_req),
        .o_s        (o_s),
        .o_r        (o_r),
        .o_busy     (o_busy),
        .o_state_q  (o_state_q),
        .o_conflict (o_conflict)
    );

    typedef struct packed {
        int kind;
        int start;
        int len;
    } pulse_t;

    pulse_t exp_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;

    // Reference model state: sync pipeline, filtered levels, stability runs,
    // pending requests, and the pulse currently in flight by timestamp.
    bit m_s1[2];
    bit m_s2[2];
    bit m_filt[2];
    bit m_rose[2];
    bit m_pend[2];
    int m_run[2];
    int act_kind  = -1;
    int act_start = 0;
    int next_dec  = 0;
    bit m_state_q = 1'b0;
    bit m_busy    = 1'b0;

    task automatic push(input int k, input int s, input int l);
        pulse_t p;
        p.kind = k; p.start = s; p.len = l;
        exp_q.push_back(p);
    endtask

    task automatic model_edge();
        bit rq[2];
        bit evt[2];
        bit s2pre;
        rq[0] = i_set_req;
        rq[1] = i_rst_req;
        cyc++;
        if (i_rst) begin
            if (act_kind >= 0) push(act_kind, act_start, cyc - act_start);
            act_kind = -1;
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_filt[c] = 1'b0;
                m_rose[c] = 1'b0; m_pend[c] = 1'b0; m_run[c] = 0;
            end
            m_state_q = 1'b0;
            next_dec  = cyc + 1;
            m_busy    = 1'b0;
            return;
        end
        if (act_kind >= 0 && cyc == act_start + PUL) begin
            push(act_kind, act_start, PUL);
            m_state_q = (act_kind == K_SET);
            act_kind  = -1;
        end
        evt[0] = m_rose[0];
        evt[1] = m_rose[1];
        if (cyc >= next_dec) begin
            if ((evt[0] | m_pend[0]) && (evt[1] | m_pend[1])) begin
                push(K_CONF, cyc, 1);
                m_pend[0] = 1'b0;
                m_pend[1] = 1'b0;
            end else if (evt[0] | m_pend[0]) begin
                act_kind = K_SET; act_start = cyc; m_pend[0] = 1'b0;
                next_dec = cyc + PUL + GAP + 1;
            end else if (evt[1] | m_pend[1]) begin
                act_kind = K_RST; act_start = cyc; m_pend[1] = 1'b0;
                next_dec = cyc + PUL + GAP + 1;
            end
        end else begin
            m_pend[0] = m_pend[0] | evt[0];
            m_pend[1] = m_pend[1] | evt[1];
        end
        for (int c = 0; c < 2; c++) begin
            s2pre     = m_s2[c];
            m_rose[c] = 1'b0;
            if (s2pre != m_filt[c]) begin
                m_run[c]++;
                if (m_run[c] >= DEB) begin
                    m_filt[c] = s2pre;
                    m_run[c]  = 0;
                    m_rose[c] = s2pre;
                end
            end else begin
                m_run[c] = 0;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = rq[c];
        end
        m_busy = (cyc + 1 < next_dec);
    endtask

    initial begin
        forever begin
            @(posedge i_clk);
            model_edge();
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic check_pulse(input int k, input int s, input int l);
        pulse_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pulse_extra: got kind %0d start %0d len %0d, expected none", k, s, l);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.start != s || e.len != l) begin
                n_bad++;
                $display("FAIL pulse: got kind %0d start %0d len %0d, expected kind %0d start %0d len %0d",
                         k, s, l, e.kind, e.start, e.len);
            end
        end
    endtask

    int mon_run[3];
    int mon_st[3];

    // Monitor: per-cycle level checks plus pulse reconstruction for the scoreboard.
    initial begin
        logic cur[3];
        for (int k = 0; k < 3; k++) begin mon_run[k] = 0; mon_st[k] = 0; end
        forever begin
            @(negedge i_clk);
            chk("busy", o_busy, m_busy);
            chk("state_q", o_state_q, m_state_q);
            chk("s_and_r", o_s & o_r, 1'b0);
            cur[0] = o_s; cur[1] = o_r; cur[2] = o_conflict;
            for (int k = 0; k < 3; k++) begin
                if (cur[k] === 1'b1) begin
                    if (mon_run[k] == 0) mon_st[k] = cyc;
                    mon_run[k]++;
                end else if (mon_run[k] > 0) begin
                    check_pulse(k, mon_st[k], mon_run[k]);
                    mon_run[k] = 0;
                end
            end
        end
    end

    task automatic drive(input logic s, input logic r, input int n);
        @(negedge i_clk);
        i_set_req = s;
        i_rst_req = r;
        repeat (n - 1) @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1; i_set_req = 1'b0; i_rst_req = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        drive(1'b0, 1'b0, 20);
        // clean set
        drive(1'b1, 1'b0, 16);
        drive(1'b0, 1'b0, 20);
        // short reset glitch
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 12);
        // simultaneous requests
        drive(1'b1, 1'b1, 15);
        drive(1'b0, 1'b0, 20);
        // reset request arriving while the set pulse is busy
        drive(1'b1, 1'b0, 2);
        drive(1'b1, 1'b1, 16);
        drive(1'b0, 1'b0, 25);
        // reset during the second cycle of o_s with set held
        drive(1'b1, 1'b0, 8);
        @(negedge i_clk); i_rst = 1'b1;
        @(negedge i_clk); i_rst = 1'b0;
        drive(1'b1, 1'b0, 15);
        drive(1'b0, 1'b0, 20);
        // randomized levels, glitches and occasional resets
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge i_clk); i_rst = 1'b1;
                @(negedge i_clk); i_rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 10));
        end
        drive(1'b0, 1'b0, 30);
        @(posedge i_clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pulse_missing: got %0d unmatched, expected 0", exp_q.size());
        end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (mon_run[k] != 0) begin
                n_bad++;
                $display("FAIL output_stuck kind %0d: got run %0d, expected 0", k, mon_run[k]);
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
